// File: rtl/afifo_pkg.sv
// Shared helpers for the asynchronous FIFO halves: pointer sizing and
// binary/Gray conversion on a 32-bit carrier (callers cast to pointer width).
package afifo_pkg;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_sync2.sv
// Two-flop synchroniser for multi-bit Gray pointers crossing clock domains.
module afifo_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/afifo_wr_mem.sv
// Write-domain half of the async FIFO: storage, write pointer and full/level status.
// Optional packet commit (w_last/w_drop) is enabled by defining AFIFO_PKT_COMMIT_EN.
module afifo_wr_mem
    import afifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int AF_MARGIN = 2
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_en,
    input  logic [WIDTH-1:0]  w_data,
`ifdef AFIFO_PKT_COMMIT_EN
    input  logic              w_last,
    input  logic              w_drop,
`endif
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              w_ovf,
    output logic [ADDR_W:0]   wptr_gray,
    input  logic [ADDR_W:0]   rptr_gray,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [WIDTH-1:0]  r_data
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam int PTR_W = ptr_w(ADDR_W);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] next_wptr;
    logic [PTR_W-1:0] gray_n;
    logic [PTR_W-1:0] rq2;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_n;
    logic             wr_acc;
    logic             ovf_n;

    afifo_sync2 #(.WIDTH(PTR_W)) u_rptr_sync (
        .clk (w_clk),
        .rst (w_rst),
        .d   (rptr_gray),
        .q   (rq2)
    );

    assign rbin_s = PTR_W'(gray2bin(32'(rq2)));

`ifdef AFIFO_PKT_COMMIT_EN
    logic [PTR_W-1:0] cptr_bin;
    logic [PTR_W-1:0] next_cptr;

    // A drop rewinds to the last committed packet boundary and discards any write.
    always_comb begin
        wr_acc    = w_en && !full && !w_drop;
        ovf_n     = w_en && full && !w_drop;
        next_wptr = wptr_bin;
        if (w_drop) begin
            next_wptr = cptr_bin;
        end else if (wr_acc) begin
            next_wptr = wptr_bin + 1'b1;
        end
        next_cptr = (wr_acc && w_last) ? next_wptr : cptr_bin;
        gray_n    = PTR_W'(bin2gray(32'(next_cptr)));
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cptr_bin <= '0;
        end else begin
            cptr_bin <= next_cptr;
        end
    end
`else
    always_comb begin
        wr_acc    = w_en && !full;
        ovf_n     = w_en && full;
        next_wptr = wr_acc ? wptr_bin + 1'b1 : wptr_bin;
        gray_n    = PTR_W'(bin2gray(32'(next_wptr)));
    end
`endif

    assign level_n = next_wptr - rbin_s;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wptr_bin    <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            w_ovf       <= 1'b0;
        end else begin
            wptr_bin    <= next_wptr;
            wptr_gray   <= gray_n;
            full        <= (level_n == PTR_W'(DEPTH));
            almost_full <= (level_n >= PTR_W'(DEPTH - AF_MARGIN));
            w_level     <= level_n;
            w_ovf       <= ovf_n;
        end
    end

    // Storage is intentionally not reset; the read domain is reset alongside.
    always_ff @(posedge w_clk) begin
        if (wr_acc) begin
            mem[wptr_bin[ADDR_W-1:0]] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: tb/tb_afifo_wr_mem.sv
// Scoreboard bench for afifo_wr_mem (ADDR_W=3, WIDTH=8, AF_MARGIN=2).
module tb_afifo_wr_mem;

    logic       w_clk = 1'b0;
    logic       w_rst;
    logic       w_en;
    logic [7:0] w_data;
    logic       full;
    logic       almost_full;
    logic [3:0] w_level;
    logic       w_ovf;
    logic [3:0] wptr_gray;
    logic [3:0] rptr_gray;
    logic [2:0] r_addr;
    logic [7:0] r_data;
`ifdef AFIFO_PKT_COMMIT_EN
    logic       w_last;
    logic       w_drop;
`endif

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam int S_FULL = 0, S_AF = 1, S_LVL = 2, S_OVF = 3, S_GRAY = 4, S_RDATA = 5;

    afifo_wr_mem #(.WIDTH(8), .ADDR_W(3), .AF_MARGIN(2)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_en        (w_en),
        .w_data      (w_data),
`ifdef AFIFO_PKT_COMMIT_EN
        .w_last      (w_last),
        .w_drop      (w_drop),
`endif
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .w_ovf       (w_ovf),
        .wptr_gray   (wptr_gray),
        .rptr_gray   (rptr_gray),
        .r_addr      (r_addr),
        .r_data      (r_data)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] dut_val(input int sel);
        case (sel)
            S_FULL:  return {31'd0, full};
            S_AF:    return {31'd0, almost_full};
            S_LVL:   return {28'd0, w_level};
            S_OVF:   return {31'd0, w_ovf};
            S_GRAY:  return {28'd0, wptr_gray};
            default: return {24'd0, r_data};
        endcase
    endfunction

    // Monitor: status is stable mid-cycle, so drain pending expectations on negedge.
    initial begin
        forever begin
            @(negedge w_clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                logic [31:0] got;
                e   = exp_q.pop_front();
                got = dut_val(e.sel);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, got, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
        exp_q.push_back('{nm, sel, v});
    endtask

    function automatic logic [3:0] g4(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic last);
        w_en   = 1'b1;
        w_data = d;
`ifdef AFIFO_PKT_COMMIT_EN
        w_last = last;
`else
        if (last) w_data = d;
`endif
        step();
        w_en = 1'b0;
`ifdef AFIFO_PKT_COMMIT_EN
        w_last = 1'b0;
`endif
    endtask

    task automatic do_reset();
        w_rst = 1'b1;
        rptr_gray = 4'd0;
        step();
        w_rst = 1'b0;
    endtask

    initial begin
        w_rst = 1'b1; w_en = 1'b0; w_data = 8'd0; rptr_gray = 4'd0; r_addr = 3'd0;
`ifdef AFIFO_PKT_COMMIT_EN
        w_last = 1'b0; w_drop = 1'b0;
`endif
        step();
        expect_val("rst_full", S_FULL, 0);
        expect_val("rst_af", S_AF, 0);
        expect_val("rst_level", S_LVL, 0);
        expect_val("rst_ovf", S_OVF, 0);
        expect_val("rst_gray", S_GRAY, 0);
        step();
        w_rst = 1'b0;

        // Fill to full.
        for (int i = 0; i < 8; i++) begin
            wr(8'h10 + 8'(i), 1'b1);
            expect_val("fill_level", S_LVL, 32'(i + 1));
            expect_val("fill_af", S_AF, (i + 1 >= 6) ? 1 : 0);
            expect_val("fill_full", S_FULL, (i + 1 == 8) ? 1 : 0);
        end
        expect_val("fill_gray", S_GRAY, 32'h0000_000c);
        for (int a = 0; a < 8; a++) begin
            r_addr = 3'(a);
            expect_val("fill_rdata", S_RDATA, 32'h10 + 32'(a));
            step();
        end

        // Overflow attempt.
        wr(8'hAA, 1'b1);
        expect_val("ovf_pulse", S_OVF, 1);
        expect_val("ovf_level", S_LVL, 8);
        expect_val("ovf_full", S_FULL, 1);
        step();
        expect_val("ovf_clear", S_OVF, 0);
        expect_val("ovf_gray", S_GRAY, 32'h0000_000c);
        r_addr = 3'd0;
        expect_val("ovf_mem", S_RDATA, 32'h10);
        step();

        // Read pointer advances to 3; synchroniser delays the release.
        rptr_gray = 4'b0010;
        step();
        expect_val("rel_full_held", S_FULL, 1);
        step();
        step();
        expect_val("rel_full", S_FULL, 0);
        expect_val("rel_af", S_AF, 0);
        expect_val("rel_level", S_LVL, 5);
        step();

        // Wrap with the reader tracking writes; level settles at the sync lag of 3.
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            wr(8'(n), 1'b1);
            rptr_gray = g4(n);
            expect_val("wrap_full", S_FULL, 0);
            expect_val("wrap_gray", S_GRAY, 32'(g4(n % 16)));
            expect_val("wrap_level", S_LVL, (n < 3) ? 32'(n) : 32'd3);
        end
        step();

        // Asynchronous reset mid-burst.
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), 1'b1);
        w_rst = 1'b1;
        rptr_gray = 4'd0;
        expect_val("arst_level", S_LVL, 0);
        expect_val("arst_gray", S_GRAY, 0);
        expect_val("arst_full", S_FULL, 0);
        expect_val("arst_af", S_AF, 0);
        step();
        w_rst = 1'b0;
        wr(8'h55, 1'b1);
        r_addr = 3'd0;
        expect_val("arst_wr_level", S_LVL, 1);
        expect_val("arst_wr_gray", S_GRAY, 1);
        expect_val("arst_wr_addr0", S_RDATA, 32'h55);
        step();

`ifdef AFIFO_PKT_COMMIT_EN
        do_reset();
        wr(8'h61, 1'b0);
        expect_val("pkt_uncommitted_gray", S_GRAY, 0);
        wr(8'h62, 1'b0);
        wr(8'h63, 1'b1);
        expect_val("pkt_commit_gray", S_GRAY, 32'(g4(3)));
        wr(8'h64, 1'b0);
        wr(8'h65, 1'b0);
        expect_val("pkt_staged_level", S_LVL, 5);
        expect_val("pkt_staged_gray", S_GRAY, 32'(g4(3)));
        w_drop = 1'b1;
        w_en   = 1'b1;
        w_data = 8'hEE;
        step();
        w_drop = 1'b0;
        w_en   = 1'b0;
        expect_val("pkt_drop_level", S_LVL, 3);
        expect_val("pkt_drop_gray", S_GRAY, 32'(g4(3)));
        step();
`endif

        step();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/afifo_wr_mem.md
Name: afifo_wr_mem

Overview:
- Write-domain half of the asynchronous FIFO, and the parametrised successor of the plain dual-port storage block.
- Holds the 2**ADDR_W-entry storage array and owns the binary/Gray write pointer.
- Synchronises the read-domain Gray pointer with two flops and produces registered full, almost-full, level and overflow status in w_clk.
- The read side gets a combinational read port; the read-domain block registers r_data.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
- AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN; legal range 1..DEPTH-1.

Ports:
- w_clk  in  1  write clock.
- w_rst  in  1  asynchronous, active-high reset.
- w_en  in  1  write request.
- w_data  in  WIDTH  write data.
- full  out  1  no free entry; writes are ignored.
- almost_full  out  1  free entries <= AF_MARGIN.
- w_level  out  ADDR_W+1  occupancy as seen from the write domain (0..DEPTH).
- w_ovf  out  1  one-cycle pulse when a write is attempted while full.
- wptr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
- rptr_gray  in  ADDR_W+1  Gray read pointer from the read domain (asynchronous).
- r_addr  in  ADDR_W  read address, driven from the read domain.
- r_data  out  WIDTH  mem[r_addr], combinational.

Behaviour:
- Clock and reset: one clock, w_clk; reset is w_rst, asynchronous, active-high.
- Reset values: wptr_bin, wptr_gray, both sync flops, full, almost_full, w_level and w_ovf are all 0. Storage is not reset.
- Pointer: wptr_bin is ADDR_W+1 bits. The MSB is the wrap bit; the low ADDR_W bits address mem.
- Gray encoding: gray = bin ^ (bin >> 1). wptr_gray is registered directly from the next binary value, so it is glitch-free.
- Synchroniser: rptr_gray passes through two w_clk flops to give rq2. rq2 is converted Gray-to-binary to give rbin_s.
- Accepted write: w_en && !full. On the same edge, mem[wptr_bin[ADDR_W-1:0]] <= w_data and wptr_bin increments, wrapping modulo 2**(ADDR_W+1).
- Rejected write: w_en && full. Memory and pointer are unchanged; w_ovf = 1 for exactly the next cycle.
- Status registers, computed from next_wptr and the current rbin_s:
  - level_n = next_wptr - rbin_s, modulo 2**(ADDR_W+1).
  - full <= (level_n == DEPTH).
  - almost_full <= (level_n >= DEPTH-AF_MARGIN).
  - w_level <= level_n.
- Latency:
  - full asserts on the edge that accepts the DEPTH-th outstanding write.
  - Deassertion is pessimistic: it follows a read-pointer change by 2 to 3 w_clk edges because of the synchroniser.
- Simultaneous write and pointer update: both are used on the same edge. level_n reflects both changes.
- Read port:
  - r_data = mem[r_addr], with no w_clk dependency on the read path.
  - A read of the entry being written on the same edge returns the old data. The FIFO protocol guarantees this never happens on a live entry.
- Reset mid-operation: all state returns to the reset values immediately. Storage contents are stale; the read domain must be reset together with this block.

Optional Feature:
- Macro: AFIFO_PKT_COMMIT_EN.
- When defined:
  - Adds inputs w_last and w_drop, plus an internal commit pointer cptr_bin (reset 0).
  - An accepted write with w_last=1 sets cptr_bin to the incremented wptr_bin.
  - wptr_gray encodes cptr_bin, so the reader sees only whole packets.
  - w_drop=1 restores wptr_bin to cptr_bin on the next edge. If w_en is also high that cycle, the drop wins and the write is discarded.
  - full, almost_full and w_level use the staged wptr_bin.
- When not defined: wptr_gray tracks wptr_bin every write. No extra ports are present.

Decomposition:
- Shared package afifo_pkg:
  - function bin2gray.
  - function gray2bin.
  - localparam-style DEPTH derivation.
  - pointer width helper PTR_W = ADDR_W+1.
- One sub-module: afifo_sync2, a parametrised N-bit two-flop synchroniser with asynchronous active-high reset. The read-side block reuses it for the write pointer.

Test Plan (ADDR_W=3, WIDTH=8, AF_MARGIN=2, rptr_gray held 0 unless stated):
- Reset, then 8 writes of 0x10..0x17 -> w_level counts 1..8; almost_full rises after the 6th write; full rises after the 8th; wptr_gray=4'b1100; r_addr 0..7 returns 0x10..0x17.
- While full, w_en=1 with data 0xAA -> mem unchanged, w_level=8, w_ovf high for exactly 1 cycle.
- From full, step rptr_gray to gray(3)=4'b0010 -> full and almost_full clear 2 to 3 w_clk later; w_level=5.
- Wrap: rptr tracks writes, 20 writes total -> wptr_bin wraps past 15 to 4; wptr_gray sequence changes one bit per write; full never asserts.
- Assert w_rst mid-burst after 5 writes -> all outputs 0 asynchronously; the next write goes to address 0.
- AFIFO_PKT_COMMIT_EN defined:
  - 3 writes with w_last on the 3rd -> wptr_gray=gray(3).
  - Then 2 writes followed by w_drop -> wptr_gray stays gray(3); w_level returns to 3.
